mdu_sched: RTL and testbench

Sequencing controller for the multiply/divide unit shared by the decode and execute stages of the five-stage MIPS pipeline.
- Accepts mult/multu/div/divu issues and mthi/mtlo writes from E.
- Runs a fixed-latency busy counter and owns the HI/LO registers.
- Produces the decode-stage stall whenever a D-stage MDU-class instruction would observe an in-flight operation.
- Suppresses issues flushed by an interrupt or exception.

---
 rtl/mdu_sched.sv | 159 +++++++++++++++
 tb/tb_mdu_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_sched.sv
// mdu_sched: sequencing controller for the shared multiply/divide unit.
//
// Accepts mult/multu/div/divu issues and mthi/mtlo writes from the E stage.
// Runs a fixed-latency busy counter and owns the HI/LO registers. Produces
// the decode-stage stall for MDU-class instructions.
//
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   Start             E-stage mult/multu/div/divu
//   MoveWE            E-stage mthi/mtlo
//   MDUOp[2:0]        0 mult, 1 multu, 2 div, 3 divu, 6 mthi, 7 mtlo
//   A, B              forwarded rs / rt operands
//   D_MDUClass        D-stage instruction is MDU-class
//   IntExcReq         E-stage instruction flushed this cycle
//   Busy              operation in flight
//   Stall             freeze PC/F/D, bubble E (combinational)
//   HI, LO            architectural HI/LO registers
//
// Build option: define MDU_FAST_EN to force both latencies to 1.
module mdu_sched #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Start,
  input  logic        MoveWE,
  input  logic [2:0]  MDUOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        D_MDUClass,
  input  logic        IntExcReq,
  output logic        Busy,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

`ifdef MDU_FAST_EN
  localparam logic [3:0] MultCnt = 4'd1;
  localparam logic [3:0] DivCnt  = 4'd1;
`else
  localparam logic [3:0] MultCnt = 4'(MULT_LAT);
  localparam logic [3:0] DivCnt  = 4'(DIV_LAT);
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;

  logic issue, move;

  // Issue only ops 0..3 (MDUOp[2] clear); move only ops 6/7.
  assign issue = Start & ~IntExcReq & (state_q == StIdle) & ~MDUOp[2];
  assign move  = MoveWE & ~Start & ~IntExcReq & (state_q == StIdle) & (MDUOp[2:1] == 2'b11);

  // Products from latched operands.
  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'b0, a_q} * {32'b0, b_q};

  // Sign-magnitude division; avoids signed overflow for 0x80000000 / -1,
  // whose magnitude quotient 0x80000000 negates back to itself.
  logic        div_signed, a_neg, b_neg, div_zero;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
  assign div_signed = ~op_q[0];
  assign a_neg      = div_signed & a_q[31];
  assign b_neg      = div_signed & b_q[31];
  assign a_mag      = a_neg ? (32'd0 - a_q) : a_q;
  assign b_mag      = b_neg ? (32'd0 - b_q) : b_q;
  assign div_zero   = (b_q == 32'd0);
  assign q_mag      = div_zero ? 32'd0 : (a_mag / b_mag);
  assign r_mag      = div_zero ? 32'd0 : (a_mag % b_mag);
  assign quot       = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
  assign rem        = a_neg ? (32'd0 - r_mag) : r_mag;

  logic [31:0] res_hi, res_lo;
  always_comb begin
    res_hi = hi_q;
    res_lo = lo_q;
    if (op_q[1]) begin
      res_hi = rem;
      res_lo = quot;
    end else if (op_q[0]) begin
      res_hi = prod_u[63:32];
      res_lo = prod_u[31:0];
    end else begin
      res_hi = prod_s[63:32];
      res_lo = prod_s[31:0];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (issue) begin
          state_d = StRun;
          cnt_d   = MDUOp[1] ? DivCnt : MultCnt;
          op_d    = MDUOp[1:0];
          a_d     = A;
          b_d     = B;
        end else if (move) begin
          if (MDUOp[0]) lo_d = A;
          else          hi_d = A;
        end
      end
      StRun: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = StIdle;
          // Divide by zero runs full latency but leaves HI/LO untouched.
          if (!(op_q[1] && div_zero)) begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      op_q    <= 2'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy  = (state_q == StRun);
  assign Stall = D_MDUClass & (Busy | Start);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_mdu_sched.sv
module tb_mdu_sched;

`ifdef MDU_FAST_EN
  localparam int MultLat = 1;
  localparam int DivLat  = 1;
`else
  localparam int MultLat = 5;
  localparam int DivLat  = 10;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        Start, MoveWE, D_MDUClass, IntExcReq;
  logic [2:0]  MDUOp;
  logic [31:0] A, B;
  logic        Busy, Stall;
  logic [31:0] HI, LO;

  mdu_sched #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk        (clk),
    .reset      (reset),
    .Start      (Start),
    .MoveWE     (MoveWE),
    .MDUOp      (MDUOp),
    .A          (A),
    .B          (B),
    .D_MDUClass (D_MDUClass),
    .IntExcReq  (IntExcReq),
    .Busy       (Busy),
    .Stall      (Stall),
    .HI         (HI),
    .LO         (LO)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
  endtask

  // Reference model: pending result scheduled for an absolute edge number.
  int          edge_no = 0;
  int          done_at = 0;
  bit          m_pend  = 0;
  bit          r_wr;
  logic [31:0] m_hi = 0, m_lo = 0, r_hi, r_lo;
  int          busy_cycles, stall_cycles;

  function automatic void compute(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b, output logic [31:0] hi,
                                  output logic [31:0] lo, output bit wr);
    longint          p, sa, sb, q, r;
    longint unsigned ua, ub, up;
    wr = 1;
    hi = 0;
    lo = 0;
    case (op)
      3'd0: begin
        p  = longint'($signed(a)) * longint'($signed(b));
        hi = p[63:32];
        lo = p[31:0];
      end
      3'd1: begin
        ua = a; ub = b; up = ua * ub;
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd2: begin
        if (b == 0) wr = 0;
        else begin
          sa = longint'($signed(a)); sb = longint'($signed(b));
          q = sa / sb; r = sa % sb;
          lo = q[31:0];
          hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) wr = 0;
        else begin
          lo = a / b;
          hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic cycle(input bit st, input bit mv, input bit d, input bit ie,
                       input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bit busy_before;
    @(negedge clk);
    Start = st; MoveWE = mv; D_MDUClass = d; IntExcReq = ie;
    MDUOp = op; A = a; B = b;
    #1;
    check("stall", Stall, 32'(d & (m_pend | st)));
    check("busy", Busy, 32'(m_pend));
    check("hi", HI, m_hi);
    check("lo", LO, m_lo);
    if (Busy)  busy_cycles++;
    if (Stall) stall_cycles++;
    @(posedge clk);
    edge_no++;
    busy_before = m_pend;
    if (m_pend && edge_no == done_at) begin
      if (r_wr) begin m_hi = r_hi; m_lo = r_lo; end
      m_pend = 0;
    end
    if (st && !ie && !busy_before && op < 4) begin
      compute(op, a, b, r_hi, r_lo, r_wr);
      m_pend  = 1;
      done_at = edge_no + ((op < 2) ? MultLat : DivLat);
    end else if (mv && !st && !ie && !busy_before && op >= 6) begin
      if (op == 3'd7) m_lo = a;
      else            m_hi = a;
    end
  endtask

  task automatic idle(input int n, input bit d);
    for (int i = 0; i < n; i++) cycle(0, 0, d, 0, 3'd0, 32'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    Start = 0; MoveWE = 0; D_MDUClass = 1; IntExcReq = 0;
    #2 reset = 1;
    #1;
    check("rst_busy", Busy, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    check("rst_stall", Stall, 32'd0);
    m_pend = 0; m_hi = 0; m_lo = 0;
    #1 reset = 0;
  endtask

  logic [31:0] sv_hi, sv_lo;

  initial begin
    reset = 1; Start = 0; MoveWE = 0; D_MDUClass = 1; IntExcReq = 0;
    MDUOp = 0; A = 0; B = 0;
    #2;
    check("reset_busy", Busy, 32'd0);
    check("reset_hi", HI, 32'd0);
    check("reset_lo", LO, 32'd0);
    check("reset_stall_idle", Stall, 32'd0);
    Start = 1;
    #0.5;
    check("reset_stall_start", Stall, 32'd1);
    Start = 0;
    #0.5 reset = 0;

    // mult -2 * 3
    busy_cycles = 0;
    cycle(1, 0, 0, 0, 3'd0, 32'hFFFF_FFFE, 32'd3);
    idle(DivLat + 2, 0);
    check("mult_lat", busy_cycles, MultLat);
    check("mult_hi", HI, 32'hFFFF_FFFF);
    check("mult_lo", LO, 32'hFFFF_FFFA);

    // divu 100 / 7
    busy_cycles = 0;
    cycle(1, 0, 0, 0, 3'd3, 32'd100, 32'd7);
    idle(DivLat + 2, 0);
    check("divu_lat", busy_cycles, DivLat);
    check("divu_lo", LO, 32'd14);
    check("divu_hi", HI, 32'd2);

    // div -7 / 2
    cycle(1, 0, 0, 0, 3'd2, 32'hFFFF_FFF9, 32'd2);
    idle(DivLat + 2, 0);
    check("div_lo", LO, 32'hFFFF_FFFD);
    check("div_hi", HI, 32'hFFFF_FFFF);

    // Dependent mfhi held in D during a mult
    stall_cycles = 0;
    cycle(1, 0, 1, 0, 3'd0, 32'd7, 32'd9);
    idle(MultLat + 3, 1);
    check("stall_len", stall_cycles, MultLat + 1);
    check("stall_hi", LO, 32'd63);

    // Flushed issue
    sv_hi = HI; sv_lo = LO; busy_cycles = 0;
    cycle(1, 0, 0, 1, 3'd1, 32'd5, 32'd5);
    idle(3, 0);
    check("flush_busy", busy_cycles, 0);
    check("flush_hi", HI, sv_hi);
    check("flush_lo", LO, sv_lo);

    // IntExcReq during RUN does not cancel
    cycle(1, 0, 0, 0, 3'd3, 32'd1000, 32'd3);
    cycle(0, 0, 0, 1, 3'd0, 32'd0, 32'd0);
    idle(DivLat + 1, 0);
    check("exc_run_lo", LO, 32'd333);

    // mthi/mtlo then divide by zero
    cycle(0, 1, 0, 0, 3'd6, 32'h1234_5678, 32'd0);
    cycle(0, 1, 0, 0, 3'd7, 32'h1234_5678, 32'd0);
    cycle(0, 0, 0, 0, 3'd0, 32'd0, 32'd0);
    check("mtlo_lo", LO, 32'h1234_5678);
    cycle(1, 0, 0, 0, 3'd2, 32'd55, 32'd0);
    idle(DivLat + 2, 0);
    check("div0_hi", HI, 32'h1234_5678);
    check("div0_lo", LO, 32'h1234_5678);

    // Overflow case
    cycle(1, 0, 0, 0, 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    idle(DivLat + 2, 0);
    check("ovf_lo", LO, 32'h8000_0000);
    check("ovf_hi", HI, 32'd0);

    // Reset in the 3rd RUN cycle of a div
    cycle(1, 0, 0, 0, 3'd2, 32'd99, 32'd4);
    idle(2, 0);
    pulse_reset();
    cycle(1, 0, 0, 0, 3'd1, 32'd6, 32'd7);
    idle(MultLat + 2, 0);
    check("post_rst_lo", LO, 32'd42);

    // Back-to-back issues with Start held
    for (int i = 0; i < 3 * (MultLat + 1) + 2; i++)
      cycle(1, 0, 1, 0, 3'd0, 32'(i + 2), 32'(i + 3));
    idle(MultLat + 2, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
           ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle(($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
            $urandom_range(0, 1) == 1, ($urandom_range(0, 15) == 0),
            3'($urandom_range(0, 7)), ra, rb);
      if (i == 1500) pulse_reset();
    end
    idle(DivLat + 2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
